div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle divide sequencer serving DIV/DIVU in the execute stage; 32-step restoring (shift-subtract) division.
- Execute stage asserts start_i and holds it, stalling the pipeline, until ready_o.
- Execute stage then routes result_o into hi_o/lo_o with whilo_o set.
- Owns the divide state machine, step counter, operand latching and sign correction.

Parameters:
- DW, 32, operand width; counter width is clog2(DW)+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DW  dividend.
- opdata2_i  in  DW  divisor.
- start_i  in  1  request; held high until ready_o is seen.
- annul_i  in  1  abort the current operation (exception/flush).
- result_o  out  2*DW  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready_o  out  1  result_o valid.

Behaviour:
- Reset (rst==0 at an edge), from any state including mid-operation:
  - state=FREE, cnt=0, ready_o=0, result_o=0, working register=0.
- States: FREE, BYZERO, ON, END.
- FREE, start_i=1 and annul_i=0:
  - Latch operands. If signed_div_i, latch absolute values plus the sign of each operand.
  - If latched divisor==0, go to BYZERO; otherwise go to ON with cnt=0 and working reg = {DW'0, |dividend|, 1'b0} (2*DW+1 bits).
  - start_i=0 or annul_i=1: stay in FREE, outputs 0.
- ON, annul_i=1: go to FREE; ready_o stays 0; no result.
- ON, annul_i=0, cnt<DW, one step per cycle:
  - diff = work[2DW:DW] - {1'b0, divisor}.
  - If diff is negative (MSB=1): work = work<<1.
  - Else: work = {diff[DW-1:0], work[DW-1:0], 1'b1}.
  - cnt increments by 1.
- ON, cnt==DW:
  - quotient = work[DW-1:0]; remainder = work[2DW:DW+1].
  - If signed: negate quotient when the operand signs differ; negate remainder when the dividend is negative.
  - Go to END with ready_o=1 and result_o = {rem, quot}.
- BYZERO: next edge go to END with result_o=0 and ready_o=1.
- END:
  - start_i=0: go to FREE, ready_o=0, result_o=0.
  - start_i=1: hold result_o and ready_o.
  - annul_i in END: go to FREE.
- Latency, counting from the edge that samples start_i:
  - Normal: ready_o high after edge 34 (1 load + 32 steps + 1 fix).
  - Divide-by-zero: ready_o high after edge 2.
- Operand changes after acceptance are ignored because operands are latched.
- Signed overflow (0x80000000 / -1) wraps: quotient 0x80000000, remainder 0.
- annul_i and start_i both high in FREE: annul wins and no operation starts.
- No back-to-back start without returning through FREE; minimum one idle cycle between operations.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined: adds output div_by_zero_o (1 bit).
  - Set on entry to END via BYZERO; cleared on END->FREE, on annul and on reset.
  - Exception logic samples it alongside ready_o.
- Undefined: port absent; divide-by-zero is silently a zero result.

Decomposition:
- Shared defines file:
  - State encodings DivFree/DivByZero/DivOn/DivEnd (2 bits).
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - DoubleRegBus width.
  - New EXE_DIV_OP/EXE_DIVU_OP aluop codes.
- One natural sub-module: div_step. Purely combinational single restoring step (work in, divisor in, work out), instantiated once.

Test Plan:
- Unsigned 100/7, start held: ready_o rises after edge 34; result_o = {0x00000002, 0x0000000E}; de-assert start -> FREE, ready_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9, 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7/-2: {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 5/0: ready_o after edge 2, result_o = 0; with DIV_ZERO_FLAG_EN, div_by_zero_o=1 for exactly the END period.
- annul_i pulsed at step 10: back to FREE, ready_o never rises. Immediate next start with 0xFFFFFFFF/1 unsigned gives {0, 0xFFFFFFFF} at edge 34.
- Reset: rst=0 mid-ON (step 20) -> next edge all outputs 0, state FREE. Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Operands changed every cycle after acceptance: result still matches the operands sampled at start.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the execute-stage divide sequencer: state encodings,
// handshake constants, bus widths and the divide aluop codes.
package div_seq_pkg;

  localparam int unsigned DIV_DW           = 32;
  localparam int unsigned DOUBLE_REG_BUS_W = 2 * DIV_DW;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: trial-subtract the divisor from the
// partial remainder and shift in the resulting quotient bit.
module div_step #(
  parameter int unsigned DW = 32
) (
  input  logic [2*DW:0] work_i,
  input  logic [DW-1:0] divisor_i,
  output logic [2*DW:0] work_c
);

  logic [DW:0] diff;

  always_comb begin
    diff = work_i[2*DW:DW] - {1'b0, divisor_i};
    if (diff[DW]) begin
      work_c = {work_i[2*DW-1:0], 1'b0};
    end else begin
      work_c = {diff[DW-1:0], work_i[DW-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: latches operands, runs DW restoring steps,
// applies sign correction and holds {remainder, quotient} until start drops.
// Optional macro DIV_ZERO_FLAG_EN adds the div_by_zero_o output.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DW = DIV_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic            div_by_zero_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DW) + 1;

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*DW:0]   work_q, work_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic            signed_q, signed_d;
  logic            dvd_neg_q, dvd_neg_d;
  logic            dvs_neg_q, dvs_neg_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;
  logic            dbz_q, dbz_d;

  logic [2*DW:0]   step_work_c;
  logic [DW-1:0]   abs1, abs2;
  logic [DW-1:0]   quot, rem, quot_fix, rem_fix;

  div_step #(.DW(DW)) u_div_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_c    (step_work_c)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;
    dbz_d     = dbz_q;

    // Magnitudes for signed operands; the most negative value maps to 2^(DW-1).
    abs1 = (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i) + DW'(1) : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i) + DW'(1) : opdata2_i;

    quot     = work_q[DW-1:0];
    rem      = work_q[2*DW:DW+1];
    quot_fix = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? (~quot) + DW'(1) : quot;
    rem_fix  = (signed_q && dvd_neg_q) ? (~rem) + DW'(1) : rem;

    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        dbz_d    = 1'b0;
        if (start_i == DivStart && !annul_i) begin
          divisor_d = abs2;
          signed_d  = signed_div_i;
          dvd_neg_d = signed_div_i & opdata1_i[DW-1];
          dvs_neg_d = signed_div_i & opdata2_i[DW-1];
          if (abs2 == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            cnt_d   = '0;
            work_d  = {{DW{1'b0}}, abs1, 1'b0};
          end
        end
      end
      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
        dbz_d    = 1'b1;
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
          dbz_d    = 1'b0;
        end else if (cnt_q != CNT_W'(DW)) begin
          work_d = step_work_c;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
          dbz_d    = 1'b0;
        end
      end
      default: begin
        state_d = DivFree;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      dbz_q     <= dbz_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

`ifdef DIV_ZERO_FLAG_EN
  assign div_by_zero_o = dbz_q;
`else
  logic unused_dbz;
  assign unused_dbz = dbz_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed DIV/DIVU cases, abort/reset paths,
// operand scrambling after acceptance and a randomized back-to-back run.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_by_zero_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_by_zero_o(div_by_zero_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issue one operation, wait (bounded) for ready_o, check latency and result.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input bit scramble);
    int lat;
    bit got;
    logic [63:0] e;
    exp_q.push_back(exp);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      tick();
      lat++;
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
      end
      if (ready_o === 1'b1) got = 1'b1;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL timeout a=%h b=%h: ready_o not seen in %0d edges, required at edge %0d", a, b, lat, exp_lat);
      void'(exp_q.pop_front());
    end else begin
      if (lat != exp_lat) begin
        n_err++;
        $display("FAIL latency a=%h b=%h: ready at edge %0d, required %0d", a, b, lat, exp_lat);
      end
      e = exp_q.pop_front();
      n_vec++;
      if (result_o !== e) begin
        n_err++;
        $display("FAIL result sgn=%0b a=%h b=%h: got %h, required %h", sgn, a, b, result_o, e);
      end
`ifdef DIV_ZERO_FLAG_EN
      n_vec++;
      if (div_by_zero_o !== 1'(b == 32'h0)) begin
        n_err++;
        $display("FAIL dbz_flag b=%h: got %b, required %b", b, div_by_zero_o, (b == 32'h0));
      end
`endif
    end
  endtask

  // Hold start one more cycle (result must stay), then drop it and expect FREE outputs.
  task automatic release_op(input logic [63:0] exp);
    tick();
    n_vec++;
    if (ready_o !== 1'b1 || result_o !== exp) begin
      n_err++;
      $display("FAIL end_hold: ready=%b result=%h, required ready=1 result=%h", ready_o, result_o, exp);
    end
    start_i = 1'b0;
    tick();
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL release: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
    end
`ifdef DIV_ZERO_FLAG_EN
    n_vec++;
    if (div_by_zero_o !== 1'b0) begin
      n_err++;
      $display("FAIL dbz_clear: got %b, required 0", div_by_zero_o);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    tick();
    tick();
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    run_op(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 34, 1'b0);
    release_op({32'h0000_0002, 32'h0000_000E});
  endtask

  task automatic test_signed();
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 1'b0);
    release_op({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34, 1'b0);
    release_op({32'h0000_0001, 32'hFFFF_FFFD});
  endtask

  task automatic test_div_zero();
    run_op(1'b0, 32'd5, 32'd0, 64'h0, 2, 1'b0);
    release_op(64'h0);
  endtask

  task automatic test_annul();
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      n_vec++;
      if (ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL annul_pre edge %0d: ready=%b, required 0", i + 1, ready_o);
      end
    end
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL annul: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34, 1'b0);
    release_op({32'h0, 32'hFFFF_FFFF});
  endtask

  task automatic test_annul_wins();
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    n_vec++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL annul_wins: ready=%b, required 0", ready_o);
    end
    run_op(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 1'b0);
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL end_annul: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b0;
    start_i = 1'b0;
    tick();
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL mid_reset: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_idle: ready=%b, required 0", ready_o);
      end
    end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 1'b0);
    release_op({32'h0, 32'h8000_0000});
  endtask

  task automatic test_scramble();
    run_op(1'b1, 32'hFFFF_FF38, 32'd9, model(1'b1, 32'hFFFF_FF38, 32'd9), 34, 1'b1);
    release_op(model(1'b1, 32'hFFFF_FF38, 32'd9));
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
      s = 1'($urandom);
      run_op(s, a, b, model(s, a, b), (b == 32'h0) ? 2 : 34, 1'b1);
      release_op(model(s, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_annul_wins();
    test_mid_reset();
    test_scramble();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
